// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2(WIDTH)-stage SLL/SRL/SRA/ROR shifter with valid/ready handshake
module pipelined_barrel_shifter #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_mode,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag
);
   logic adv;
   assign adv = !out_valid || out_ready;
   assign in_ready = adv;
   for (genvar k = 0; k < SHAMT_W; k++) begin : g_st
      localparam int S = 1 << k;
      logic [WIDTH-1:0] di, nd, dq;
      logic [SHAMT_W-1:k] si;
      logic [1:0] mi;
      logic xi, vi, vq;
      logic [TAG_W-1:0] ti, tq;
      if (k == 0) begin : g_in
         assign di = in_data;
         assign si = in_shamt;
         assign mi = in_mode;
         assign xi = in_data[WIDTH-1];
         assign ti = in_tag;
         assign vi = in_valid;
      end else begin : g_in
         assign di = g_st[k-1].dq;
         assign si = g_st[k-1].g_fwd.sq;
         assign mi = g_st[k-1].g_fwd.mq;
         assign xi = g_st[k-1].g_fwd.xq;
         assign ti = g_st[k-1].tq;
         assign vi = g_st[k-1].vq;
      end
      // shift by 2^k in the operation's mode when this stage's shamt bit is set
      always_comb
         nd = !si[k] ? di :
              mi == 2'd0 ? di << S :
              mi == 2'd1 ? di >> S :
              mi == 2'd2 ? {{S{xi}}, di[WIDTH-1:S]} :
                           {di[S-1:0], di[WIDTH-1:S]};
      // data, tag and valid advance together; reset flushes in-flight operations
      always_ff @(posedge clock)
         if (reset) begin
            dq <= '0;
            tq <= '0;
            vq <= 1'b0;
         end else if (adv) begin
            dq <= nd;
            tq <= ti;
            vq <= vi;
         end
      if (k < SHAMT_W - 1) begin : g_fwd
         logic [SHAMT_W-1:k+1] sq;
         logic [1:0] mq;
         logic xq;
         // carry unconsumed shamt bits, mode and sign fill to the next stage
         always_ff @(posedge clock)
            if (reset) begin
               sq <= '0;
               mq <= '0;
               xq <= 1'b0;
            end else if (adv) begin
               sq <= si[SHAMT_W-1:k+1];
               mq <= mi;
               xq <= xi;
            end
      end
   end
   assign out_valid = g_st[SHAMT_W-1].vq;
   assign out_data  = g_st[SHAMT_W-1].dq;
   assign out_tag   = g_st[SHAMT_W-1].tq;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: scoreboard bench for directed and randomised shifter traffic
module tb_pipelined_barrel_shifter;
   logic clock, reset, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data;
   logic [4:0] in_shamt;
   logic [1:0] in_mode;
   logic [3:0] in_tag, out_tag;
   int tests = 0, fails = 0, cyc = 0, stalls = 0;
   typedef struct { logic [31:0] d; logic [3:0] t; int c; int s; } exp_t;
   exp_t q[$];

   pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(4)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
   );

   initial clock = 0;
   always #5 clock = ~clock;
   initial forever @(posedge clock) cyc++;

   function automatic logic [31:0] m32(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m);
      logic signed [31:0] sd;
      logic [63:0] r;
      sd = d;
      sd = sd >>> sh;
      r = {d, d} >> sh;
      if (m == 2'd0) return d << sh;
      if (m == 2'd1) return d >> sh;
      if (m == 2'd2) return sd;
      return r[31:0];
   endfunction

   initial forever begin
      exp_t e;
      @(negedge clock);
      if (!reset) begin
         if (out_valid && !out_ready) stalls++;
         if (out_valid && out_ready) begin
            tests++;
            assert (q.size() != 0) else begin fails++; $error("FAIL unexpected_out got=%h exp=none", out_data); end
            if (q.size() != 0) begin
               e = q.pop_front();
               tests += 3;
               assert (out_data === e.d) else begin fails++; $error("FAIL out_data got=%h exp=%h", out_data, e.d); end
               assert (out_tag === e.t) else begin fails++; $error("FAIL out_tag got=%h exp=%h", out_tag, e.t); end
               assert (cyc - e.c - (stalls - e.s) === 5) else begin fails++; $error("FAIL latency got=%0d exp=5", cyc - e.c - (stalls - e.s)); end
            end
         end
      end
   end

   task automatic send(input logic [31:0] d, input int sh, input logic [1:0] m, input logic [3:0] tg, input logic [31:0] ex);
      logic a;
      int n;
      in_valid = 1; in_data = d; in_shamt = 5'(sh); in_mode = m; in_tag = tg;
      a = 0; n = 0;
      while (!a && n < 100) begin
         @(negedge clock);
         a = in_ready;
         @(posedge clock); #1;
         n++;
      end
      tests++;
      assert (a === 1'b1) else begin fails++; $error("FAIL send_timeout got=%b exp=1 tag=%h", a, tg); end
      if (a) q.push_back('{d: ex, t: tg, c: cyc - 1, s: stalls});
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clock);
      #1;
      tests++;
      assert (q.size() === 0) else begin fails++; $error("FAIL drain got=%0d exp=0 pending", q.size()); end
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] ex);
      tests++;
      assert (got === ex) else begin fails++; $error("FAIL %s got=%h exp=%h", nm, got, ex); end
   endtask

   initial begin
      logic [31:0] sd;
      logic [3:0] st;
      reset = 1; in_valid = 0; in_data = 0; in_shamt = 0; in_mode = 0; in_tag = 0; out_ready = 1;
      repeat (3) @(posedge clock);
      #1 reset = 0;
      @(negedge clock);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", 32'(out_tag), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      @(posedge clock); #1;
      send(32'h80000001, 4, 2'd0, 4'h1, 32'h00000010); in_valid = 0; drain();
      send(32'h80000001, 4, 2'd1, 4'h2, 32'h08000000); in_valid = 0; drain();
      send(32'h80000001, 4, 2'd2, 4'h3, 32'hF8000000); in_valid = 0; drain();
      send(32'h80000001, 4, 2'd3, 4'h4, 32'h18000000); in_valid = 0; drain();
      for (int i = 0; i < 32; i++) begin
         chk("stream_in_ready", 32'(in_ready), 1);
         send(32'hFFFFFFFF, i, 2'd1, 4'(i), 32'hFFFFFFFF >> i);
      end
      in_valid = 0; drain();
      out_ready = 0;
      for (int i = 0; i < 5; i++) send(32'h12345678 + 32'(i), i + 1, 2'(i), 4'(i + 8), m32(32'h12345678 + 32'(i), 5'(i + 1), 2'(i)));
      in_valid = 0;
      @(negedge clock);
      chk("hold_out_valid", 32'(out_valid), 1);
      sd = out_data; st = out_tag;
      for (int i = 0; i < 10; i++) begin
         if (i != 0) @(negedge clock);
         chk("hold_in_ready", 32'(in_ready), 0);
         chk("hold_out_data", out_data, sd);
         chk("hold_out_tag", 32'(out_tag), 32'(st));
      end
      @(posedge clock); #1 out_ready = 1;
      for (int i = 0; i < 5; i++) send(32'hCAFEF00D ^ 32'(i), 3 * i, 2'(i), 4'(i), m32(32'hCAFEF00D ^ 32'(i), 5'(3 * i), 2'(i)));
      in_valid = 0; drain();
      send(32'h80000000, 31, 2'd2, 4'hA, 32'hFFFFFFFF);
      send(32'h00000001, 31, 2'd0, 4'hB, 32'h80000000);
      send(32'h00000001, 31, 2'd3, 4'hC, 32'h00000002);
      for (int m = 0; m < 4; m++) send(32'hA5C30F96, 0, 2'(m), 4'(m), 32'hA5C30F96);
      in_valid = 0; drain();
      for (int i = 0; i < 3; i++) send(32'h0F0F0F0F, i + 1, 2'd0, 4'(i), m32(32'h0F0F0F0F, 5'(i + 1), 2'd0));
      in_valid = 0;
      @(negedge clock);
      chk("flush_out_valid_a", 32'(out_valid), 0);
      @(posedge clock); #1 reset = 1; q.delete();
      @(negedge clock);
      chk("flush_out_valid_b", 32'(out_valid), 0);
      @(posedge clock); #1 reset = 0;
      @(negedge clock);
      chk("post_rst_out_valid", 32'(out_valid), 0);
      chk("post_rst_in_ready", 32'(in_ready), 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk("flush_no_result", 32'(out_valid), 0);
      end
      @(posedge clock); #1;
      send(32'h13579BDF, 7, 2'd3, 4'h5, m32(32'h13579BDF, 5'd7, 2'd3));
      in_valid = 0; drain();
      for (int i = 0; i < 200; i++) begin
         in_valid = 1'($urandom_range(0, 1)); in_data = $urandom; in_shamt = 5'($urandom);
         in_mode = 2'($urandom); in_tag = 4'($urandom); out_ready = $urandom_range(0, 3) != 0;
         @(negedge clock);
         if (in_valid && in_ready) q.push_back('{d: m32(in_data, in_shamt, in_mode), t: in_tag, c: cyc, s: stalls});
         @(posedge clock); #1;
      end
      in_valid = 0; out_ready = 1; drain();
      for (int i = 0; i < 5000 && !(g_rnd[0].done && g_rnd[1].done); i++) @(posedge clock);
      tests++;
      assert (g_rnd[0].done && g_rnd[1].done) else begin fails++; $error("FAIL rnd_done got=%b%b exp=11", g_rnd[1].done, g_rnd[0].done); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   for (genvar g = 0; g < 2; g++) begin : g_rnd
      localparam int W = g ? 64 : 16;
      localparam int SW = $clog2(W);
      logic rst, iv, ir, ov, ordy, done;
      logic [W-1:0] id, od;
      logic [SW-1:0] ish;
      logic [1:0] im;
      logic [3:0] it, ot;
      logic [W-1:0] qd[$];
      logic [3:0] qt[$];
      int qc[$], qs[$];

      pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(4)) dut_r (
         .clock(clock), .reset(rst), .in_valid(iv), .in_ready(ir),
         .in_data(id), .in_shamt(ish), .in_mode(im), .in_tag(it),
         .out_valid(ov), .out_ready(ordy), .out_data(od), .out_tag(ot)
      );

      function automatic logic [W-1:0] mdl(input logic [W-1:0] d, input logic [SW-1:0] sh, input logic [1:0] m);
         logic signed [W-1:0] sd;
         logic [2*W-1:0] r;
         sd = d;
         sd = sd >>> sh;
         r = {d, d} >> sh;
         if (m == 2'd0) return d << sh;
         if (m == 2'd1) return d >> sh;
         if (m == 2'd2) return sd;
         return r[W-1:0];
      endfunction

      initial begin
         logic [W-1:0] ed;
         logic [3:0] et;
         int ec, es, st;
         done = 0; st = 0; rst = 1; iv = 0; ordy = 1; id = '0; ish = '0; im = '0; it = '0;
         repeat (3) @(posedge clock);
         #1 rst = 0;
         for (int i = 0; i < 460; i++) begin
            if (i < 400) begin
               iv = 1'($urandom_range(0, 1)); id = W'({$urandom, $urandom}); ish = SW'($urandom);
               im = 2'($urandom); it = 4'($urandom); ordy = $urandom_range(0, 3) != 0;
            end else begin
               iv = 0; ordy = 1;
            end
            @(negedge clock);
            if (ov && !ordy) st++;
            if (iv && ir) begin
               qd.push_back(mdl(id, ish, im)); qt.push_back(it); qc.push_back(cyc); qs.push_back(st);
            end
            if (ov && ordy) begin
               tests++;
               assert (qd.size() != 0) else begin fails++; $error("FAIL rnd%0d_unexpected got=%h exp=none", W, od); end
               if (qd.size() != 0) begin
                  ed = qd.pop_front(); et = qt.pop_front(); ec = qc.pop_front(); es = qs.pop_front();
                  tests += 3;
                  assert (od === ed) else begin fails++; $error("FAIL rnd%0d_data got=%h exp=%h", W, od, ed); end
                  assert (ot === et) else begin fails++; $error("FAIL rnd%0d_tag got=%h exp=%h", W, ot, et); end
                  assert (cyc - ec - (st - es) === SW) else begin fails++; $error("FAIL rnd%0d_latency got=%0d exp=%0d", W, cyc - ec - (st - es), SW); end
               end
            end
            @(posedge clock); #1;
         end
         tests++;
         assert (qd.size() === 0) else begin fails++; $error("FAIL rnd%0d_lost got=%0d exp=0", W, qd.size()); end
         done = 1;
      end
   end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the fixed-distance shifters in the ALU shift path.
- Takes a WIDTH-bit operand, a run-time shift amount and a mode; performs logical-left, logical-right, arithmetic-right or rotate-right.
- One register stage per shift-amount bit, so the design sustains one operation per clock.
- Uses a valid/ready handshake on input and output, so it can sit between the operand-issue logic and the ALU result mux under backpressure.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of two and at least 4.
- SHAMT_W, log2(WIDTH) (5 for 32), shift-amount width; derived, not overridden.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  shifter can accept a request this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Clock, reset and reset values:
  - One clock domain.
  - Reset is synchronous and active-high.
  - Reset clears every stage valid bit, data register and tag register to 0.
  - After reset: out_valid=0, out_data=0, out_tag=0, in_ready=1.
- Pipeline structure:
  - SHAMT_W stages, numbered k=0..SHAMT_W-1.
  - Stage k shifts by 2^k when shamt bit k is 1; otherwise it passes the value through unchanged.
  - Each stage registers data, the remaining shamt bits, mode, tag and a valid bit.
  - Latency is SHAMT_W cycles from an accepted input to out_valid, i.e. 5 for WIDTH=32.
- Per-stage shift rules (s = 2^k):
  - SLL: low s bits filled with 0.
  - SRL: high s bits filled with 0.
  - SRA: high s bits filled with the original operand MSB, captured at input and carried with the operation.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- Shift amount 0 in any mode: out_data equals in_data.
- Handshake:
  - Global advance enable adv = !out_valid || out_ready.
  - in_ready = adv, a purely combinational function of out_valid and out_ready.
  - A request is accepted when in_valid && in_ready.
  - When adv=1, all stages shift forward one step. Stage 0 loads the new request if accepted; otherwise it loads a bubble (valid=0).
  - When adv=0, every stage holds its state. out_data and out_tag are stable while out_valid=1 and out_ready=0.
  - A bubble in the last stage does not stall the pipeline: out_valid=0 makes adv=1.
  - A result is consumed when out_valid && out_ready.
- Ordering: results emerge in acceptance order. No reordering or dropping occurs.
- Simultaneous events: accept and consume in the same cycle is legal and keeps full throughput of one result per cycle.
- in_data, in_shamt, in_mode and in_tag are sampled only on acceptance. Their values while in_valid=0 are don't-care.
- Reset mid-operation flushes all in-flight operations. No result for them ever appears.
- Bubble data registers may hold any value; out_data is checked only when out_valid=1.

Test Plan:
- Reset, then one request each with out_ready=1: in_data=0x80000001, shamt=4.
  - SLL -> 0x00000010.
  - SRL -> 0x08000000.
  - SRA -> 0xF8000000.
  - ROR -> 0x18000000.
  - Each appears exactly 5 cycles after acceptance, with out_tag equal to the request tag.
- Back-to-back streaming: 32 requests on consecutive cycles, data=0xFFFFFFFF, SRL, shamt=0..31, tag=shamt[3:0].
  - Results 0xFFFFFFFF>>n arrive on 32 consecutive cycles, in order.
  - in_ready stays 1 throughout.
- Backpressure: fill the pipeline, then hold out_ready=0 for 10 cycles.
  - in_ready=0 during the hold.
  - out_data and out_tag stay stable.
  - On release, all 5 queued results plus new ones drain in order, with none lost or duplicated.
- Boundary amounts:
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
  - SLL 0x00000001 by 31 -> 0x80000000.
  - ROR 0x00000001 by 31 -> 0x00000002.
  - Any mode with shamt 0 -> input unchanged.
- Reset mid-stream: accept 3 requests, then assert reset on cycle 2 after the last.
  - No out_valid pulse for the flushed requests.
  - out_valid=0 and in_ready=1 on the cycle after reset.
  - A new request then completes with correct data.
- Randomised cross-check against a reference model using WIDTH=16 and WIDTH=64 builds, with random valid/ready toggling.
  - Every result matches the model, with latency log2(WIDTH) in unstalled cycles.
